// File: rtl/bellek_asamasi.sv
// rtl/bellek_asamasi.sv - memory stage: loads/stores over a valid/ready port, misalignment reporting
//
// Purpose: takes the execute stage's registered micro-op, performs the data-memory
// access it asks for and hands the completed micro-op to write-back. The execute
// stage is held through duraklat_o while an access is outstanding.
//
// Micro-op layout (UOP_BIT = 101):
//   [0]       UOP_VALID
//   [32:1]    UOP_PC
//   [64:33]   UOP_RD      ALU result / effective address
//   [96:65]   UOP_RS2     store data
//   [100:97]  UOP_BELLEK  0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   bellek_uop_i                 micro-op from execute
//   duraklat_o                   hold request to execute (combinational)
//   bel_istek_*                  data-memory request: address, data, byte mask, write, valid/ready
//   bel_yanit_veri_i/_gecerli_i  load response, always accepted
//   ddb_odd_*                    misaligned-access exception report (one-cycle pulse)
//   geri_yaz_uop_o               registered micro-op to write-back

module bellek_asamasi #(
    parameter int ADRES_BIT = 32,
    parameter int VERI_BIT  = 32,
    localparam int UOP_BIT      = 101,
    localparam int PS_BIT       = 32,
    localparam int EXC_CODE_BIT = 4,
    localparam int MXLEN        = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [UOP_BIT-1:0]      bellek_uop_i,
    output logic                    duraklat_o,
    output logic [ADRES_BIT-1:0]    bel_istek_adres_o,
    output logic [VERI_BIT-1:0]     bel_istek_veri_o,
    output logic [VERI_BIT/8-1:0]   bel_istek_maske_o,
    output logic                    bel_istek_yaz_o,
    output logic                    bel_istek_gecerli_o,
    input  logic                    bel_istek_hazir_i,
    input  logic [VERI_BIT-1:0]     bel_yanit_veri_i,
    input  logic                    bel_yanit_gecerli_i,
    output logic [PS_BIT-1:0]       ddb_odd_ps_o,
    output logic [EXC_CODE_BIT-1:0] ddb_odd_kod_o,
    output logic [MXLEN-1:0]        ddb_odd_bilgi_o,
    output logic                    ddb_odd_gecerli_o,
    output logic [UOP_BIT-1:0]      geri_yaz_uop_o
);

    localparam int UOP_VALID      = 0;
    localparam int UOP_PC_LSB     = 1;
    localparam int UOP_RD_LSB     = 33;
    localparam int UOP_RS2_LSB    = 65;
    localparam int UOP_BELLEK_LSB = 97;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam logic [EXC_CODE_BIT-1:0] EXC_YUKLE_HIZASIZ = 4'd4;
    localparam logic [EXC_CODE_BIT-1:0] EXC_SAKLA_HIZASIZ = 4'd6;

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        ISTEK = 2'd1,
        BEKLE = 2'd2,
        TAMAM = 2'd3
    } durum_t;

    // ---------------------------------------------------------------
    // State and registered outputs
    // ---------------------------------------------------------------
    durum_t                    durum_q, durum_d;
    logic [ADRES_BIT-1:0]      adres_q, adres_d;
    logic [VERI_BIT-1:0]       veri_q, veri_d;
    logic [VERI_BIT/8-1:0]     maske_q, maske_d;
    logic                      yaz_q, yaz_d;
    logic                      istek_gecerli_q, istek_gecerli_d;
    logic [3:0]                islem_q, islem_d;
    logic [UOP_BIT-1:0]        uop_q, uop_d;
    logic [VERI_BIT-1:0]       yanit_q, yanit_d;
    logic [UOP_BIT-1:0]        gyu_q, gyu_d;
    logic [PS_BIT-1:0]         odd_ps_q, odd_ps_d;
    logic [EXC_CODE_BIT-1:0]   odd_kod_q, odd_kod_d;
    logic [MXLEN-1:0]          odd_bilgi_q, odd_bilgi_d;
    logic                      odd_gecerli_q, odd_gecerli_d;

    // ---------------------------------------------------------------
    // Input micro-op decode
    // ---------------------------------------------------------------
    logic                      giris_gecerli;
    logic [3:0]                giris_islem;
    logic [31:0]               giris_adres;
    logic [31:0]               giris_rs2;
    logic [PS_BIT-1:0]         giris_ps;
    logic                      giris_yukle;
    logic                      giris_sakla;
    logic                      giris_bellek;
    logic                      giris_hizasiz;
    logic [VERI_BIT/8-1:0]     giris_maske;
    logic [VERI_BIT-1:0]       giris_veri;

    assign giris_gecerli = bellek_uop_i[UOP_VALID];
    assign giris_islem   = bellek_uop_i[UOP_BELLEK_LSB +: 4];
    assign giris_adres   = bellek_uop_i[UOP_RD_LSB +: 32];
    assign giris_rs2     = bellek_uop_i[UOP_RS2_LSB +: 32];
    assign giris_ps      = bellek_uop_i[UOP_PC_LSB +: PS_BIT];

    always_comb begin
        giris_yukle   = 1'b0;
        giris_sakla   = 1'b0;
        giris_hizasiz = 1'b0;
        giris_maske   = 4'b1111;
        giris_veri    = '0;
        case (giris_islem)
            OP_LB, OP_LBU: giris_yukle = 1'b1;
            OP_LH, OP_LHU: begin
                giris_yukle   = 1'b1;
                giris_hizasiz = giris_adres[0];
            end
            OP_LW: begin
                giris_yukle   = 1'b1;
                giris_hizasiz = (giris_adres[1:0] != 2'b00);
            end
            OP_SB: begin
                giris_sakla = 1'b1;
                giris_maske = 4'b0001 << giris_adres[1:0];
                giris_veri  = {4{giris_rs2[7:0]}};
            end
            OP_SH: begin
                giris_sakla   = 1'b1;
                giris_hizasiz = giris_adres[0];
                giris_maske   = 4'b0011 << giris_adres[1:0];
                giris_veri    = {2{giris_rs2[15:0]}};
            end
            OP_SW: begin
                giris_sakla   = 1'b1;
                giris_hizasiz = (giris_adres[1:0] != 2'b00);
                giris_veri    = giris_rs2;
            end
            default: ;
        endcase
        giris_bellek = giris_gecerli && (giris_yukle || giris_sakla);
    end

    // ---------------------------------------------------------------
    // Load value extraction from the latched response
    // ---------------------------------------------------------------
    logic [31:0] kayik_veri;
    logic [15:0] yarim_kelime;
    logic [31:0] yukle_degeri;

    always_comb begin
        kayik_veri   = yanit_q >> {adres_q[1:0], 3'b000};
        yarim_kelime = adres_q[1] ? yanit_q[31:16] : yanit_q[15:0];
        case (islem_q)
            OP_LB:   yukle_degeri = {{24{kayik_veri[7]}}, kayik_veri[7:0]};
            OP_LBU:  yukle_degeri = {24'd0, kayik_veri[7:0]};
            OP_LH:   yukle_degeri = {{16{yarim_kelime[15]}}, yarim_kelime};
            OP_LHU:  yukle_degeri = {16'd0, yarim_kelime};
            default: yukle_degeri = yanit_q;
        endcase
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        durum_d         = durum_q;
        adres_d         = adres_q;
        veri_d          = veri_q;
        maske_d         = maske_q;
        yaz_d           = yaz_q;
        istek_gecerli_d = istek_gecerli_q;
        islem_d         = islem_q;
        uop_d           = uop_q;
        yanit_d         = yanit_q;
        // Default is a bubble: stale payload, valid bit cleared, so write-back
        // never sees the same result twice.
        gyu_d            = gyu_q;
        gyu_d[UOP_VALID] = 1'b0;
        odd_gecerli_d   = 1'b0;
        odd_ps_d        = '0;
        odd_kod_d       = '0;
        odd_bilgi_d     = '0;

        case (durum_q)
            BOSTA: begin
                if (giris_bellek) begin
                    if (giris_hizasiz) begin
                        odd_gecerli_d = 1'b1;
                        odd_ps_d      = giris_ps;
                        odd_kod_d     = giris_sakla ? EXC_SAKLA_HIZASIZ : EXC_YUKLE_HIZASIZ;
                        odd_bilgi_d   = giris_adres;
                    end else begin
                        adres_d         = giris_adres[ADRES_BIT-1:0];
                        veri_d          = giris_veri;
                        maske_d         = giris_maske;
                        yaz_d           = giris_sakla;
                        islem_d         = giris_islem;
                        uop_d           = bellek_uop_i;
                        istek_gecerli_d = 1'b1;
                        durum_d         = ISTEK;
                    end
                end else begin
                    // Non-memory ops (and invalid slots) pass straight through;
                    // an invalid input already carries a cleared valid bit.
                    gyu_d = bellek_uop_i;
                end
            end
            ISTEK: begin
                if (bel_istek_hazir_i) begin
                    istek_gecerli_d = 1'b0;
                    durum_d         = yaz_q ? TAMAM : BEKLE;
                end
            end
            BEKLE: begin
                if (bel_yanit_gecerli_i) begin
                    yanit_d = bel_yanit_veri_i;
                    durum_d = TAMAM;
                end
            end
            TAMAM: begin
                gyu_d = uop_q;
                if (!yaz_q) begin
                    gyu_d[UOP_RD_LSB +: 32] = yukle_degeri;
                end
                durum_d = BOSTA;
            end
            default: durum_d = BOSTA;
        endcase
    end

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q         <= BOSTA;
            adres_q         <= '0;
            veri_q          <= '0;
            maske_q         <= '0;
            yaz_q           <= 1'b0;
            istek_gecerli_q <= 1'b0;
            islem_q         <= OP_NOP;
            uop_q           <= '0;
            yanit_q         <= '0;
            gyu_q           <= '0;
            odd_ps_q        <= '0;
            odd_kod_q       <= '0;
            odd_bilgi_q     <= '0;
            odd_gecerli_q   <= 1'b0;
        end else begin
            durum_q         <= durum_d;
            adres_q         <= adres_d;
            veri_q          <= veri_d;
            maske_q         <= maske_d;
            yaz_q           <= yaz_d;
            istek_gecerli_q <= istek_gecerli_d;
            islem_q         <= islem_d;
            uop_q           <= uop_d;
            yanit_q         <= yanit_d;
            gyu_q           <= gyu_d;
            odd_ps_q        <= odd_ps_d;
            odd_kod_q       <= odd_kod_d;
            odd_bilgi_q     <= odd_bilgi_d;
            odd_gecerli_q   <= odd_gecerli_d;
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    // Stall is released in TAMAM so execute advances on the edge that writes
    // the result; it is forced low while reset is asserted.
    assign duraklat_o = !rst_i &&
                        ((giris_bellek && !giris_hizasiz && (durum_q != TAMAM)) ||
                         (durum_q == ISTEK) || (durum_q == BEKLE));

    assign bel_istek_adres_o   = {adres_q[ADRES_BIT-1:2], 2'b00};
    assign bel_istek_veri_o    = veri_q;
    assign bel_istek_maske_o   = maske_q;
    assign bel_istek_yaz_o     = yaz_q;
    assign bel_istek_gecerli_o = istek_gecerli_q;
    assign ddb_odd_ps_o        = odd_ps_q;
    assign ddb_odd_kod_o       = odd_kod_q;
    assign ddb_odd_bilgi_o     = odd_bilgi_q;
    assign ddb_odd_gecerli_o   = odd_gecerli_q;
    assign geri_yaz_uop_o      = gyu_q;

endmodule

// File: tb/tb_bellek_asamasi.sv
// tb/tb_bellek_asamasi.sv - self-checking bench for bellek_asamasi
module tb_bellek_asamasi;

    localparam int UOP_BIT = 101;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic [UOP_BIT-1:0]  bellek_uop_i;
    logic                duraklat_o;
    logic [31:0]         bel_istek_adres_o;
    logic [31:0]         bel_istek_veri_o;
    logic [3:0]          bel_istek_maske_o;
    logic                bel_istek_yaz_o;
    logic                bel_istek_gecerli_o;
    logic                bel_istek_hazir_i;
    logic [31:0]         bel_yanit_veri_i;
    logic                bel_yanit_gecerli_i;
    logic [31:0]         ddb_odd_ps_o;
    logic [3:0]          ddb_odd_kod_o;
    logic [31:0]         ddb_odd_bilgi_o;
    logic                ddb_odd_gecerli_o;
    logic [UOP_BIT-1:0]  geri_yaz_uop_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    bellek_asamasi dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .bellek_uop_i        (bellek_uop_i),
        .duraklat_o          (duraklat_o),
        .bel_istek_adres_o   (bel_istek_adres_o),
        .bel_istek_veri_o    (bel_istek_veri_o),
        .bel_istek_maske_o   (bel_istek_maske_o),
        .bel_istek_yaz_o     (bel_istek_yaz_o),
        .bel_istek_gecerli_o (bel_istek_gecerli_o),
        .bel_istek_hazir_i   (bel_istek_hazir_i),
        .bel_yanit_veri_i    (bel_yanit_veri_i),
        .bel_yanit_gecerli_i (bel_yanit_gecerli_i),
        .ddb_odd_ps_o        (ddb_odd_ps_o),
        .ddb_odd_kod_o       (ddb_odd_kod_o),
        .ddb_odd_bilgi_o     (ddb_odd_bilgi_o),
        .ddb_odd_gecerli_o   (ddb_odd_gecerli_o),
        .geri_yaz_uop_o      (geri_yaz_uop_o)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] adr;
        logic [31:0] rs2;
        logic [31:0] resp;
        logic [31:0] exp_rd;
        logic [3:0]  exp_mask;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_stall;
    } vec_t;

    function automatic logic [UOP_BIT-1:0] mk_uop(input logic v, input logic [31:0] pc,
                                                  input logic [31:0] rd, input logic [31:0] rs2,
                                                  input logic [3:0] op);
        return {op, rs2, rd, pc, v};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [UOP_BIT-1:0] u;
        logic [31:0] pc;
        int  cyc;
        int  req_at;
        int  stall_cnt;
        bit  done;
        bit  prev_stall;
        bit  is_load;
        bit  is_store;
        pc       = 32'h100 + idx * 4;
        u        = mk_uop(1'b1, pc, v.adr, v.rs2, v.op);
        is_load  = (v.op >= OP_LB) && (v.op <= OP_LHU);
        is_store = (v.op >= OP_SB);
        @(posedge clk_i); #1;
        bellek_uop_i = u;
        cyc = 0; req_at = -1; stall_cnt = 0; done = 0;
        while (!done && cyc < 20) begin
            @(negedge clk_i);
            prev_stall = duraklat_o;
            if (duraklat_o) stall_cnt++;
            if (bel_istek_gecerli_o && req_at < 0) begin
                req_at = cyc;
                chk($sformatf("v%0d_adres", idx), bel_istek_adres_o, {v.adr[31:2], 2'b00});
                chk($sformatf("v%0d_maske", idx), bel_istek_maske_o, v.exp_mask);
                chk($sformatf("v%0d_yaz", idx), bel_istek_yaz_o, is_store);
                if (is_store) chk($sformatf("v%0d_veri", idx), bel_istek_veri_o, v.exp_data);
            end
            if (geri_yaz_uop_o[0]) begin
                done = 1;
                if (v.op == OP_NOP) chk($sformatf("v%0d_uop", idx), geri_yaz_uop_o, u);
                chk($sformatf("v%0d_rd", idx), geri_yaz_uop_o[64:33], v.exp_rd);
                chk($sformatf("v%0d_pc", idx), geri_yaz_uop_o[32:1], pc);
                chk($sformatf("v%0d_latency", idx), cyc, v.exp_lat);
                chk($sformatf("v%0d_stall", idx), stall_cnt, v.exp_stall);
                chk($sformatf("v%0d_req_seen", idx), req_at >= 0, v.op != OP_NOP);
            end
            @(posedge clk_i); #1;
            cyc++;
            if (!prev_stall) bellek_uop_i = '0;
            bel_yanit_gecerli_i = is_load && (req_at >= 0) && (cyc == req_at + 1);
            bel_yanit_veri_i    = v.resp;
        end
        if (!done) chk($sformatf("v%0d_timeout", idx), 0, 1);
        bellek_uop_i        = '0;
        bel_yanit_gecerli_i = 1'b0;
    endtask

    vec_t tbl[12];
    logic [UOP_BIT-1:0] nxt;

    initial begin
        tbl[0]  = '{OP_NOP, 32'h0000_1234, 32'h55,        32'h0,         32'h0000_1234, 4'h0, 32'h0,         1, 0};
        tbl[1]  = '{OP_LB,  32'h0000_1003, 32'h0,         32'h80FF_FF00, 32'hFFFF_FF80, 4'hF, 32'h0,         4, 3};
        tbl[2]  = '{OP_LBU, 32'h0000_1001, 32'h0,         32'h1234_5678, 32'h0000_0056, 4'hF, 32'h0,         4, 3};
        tbl[3]  = '{OP_LH,  32'h0000_1002, 32'h0,         32'h8001_7FFF, 32'hFFFF_8001, 4'hF, 32'h0,         4, 3};
        tbl[4]  = '{OP_LHU, 32'h0000_4002, 32'h0,         32'h8765_0000, 32'h0000_8765, 4'hF, 32'h0,         4, 3};
        tbl[5]  = '{OP_LW,  32'h0000_5000, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'hF, 32'h0,         4, 3};
        tbl[6]  = '{OP_LB,  32'h0000_1000, 32'h0,         32'h0000_007F, 32'h0000_007F, 4'hF, 32'h0,         4, 3};
        tbl[7]  = '{OP_SB,  32'h0000_6001, 32'h1234_56A5, 32'h0,         32'h0000_6001, 4'h2, 32'hA5A5_A5A5, 3, 2};
        tbl[8]  = '{OP_SH,  32'h0000_6000, 32'h0000_BEEF, 32'h0,         32'h0000_6000, 4'h3, 32'hBEEF_BEEF, 3, 2};
        tbl[9]  = '{OP_SW,  32'h0000_6004, 32'hCAFE_F00D, 32'h0,         32'h0000_6004, 4'hF, 32'hCAFE_F00D, 3, 2};
        tbl[10] = '{OP_SB,  32'h0000_6003, 32'h0000_0077, 32'h0,         32'h0000_6003, 4'h8, 32'h7777_7777, 3, 2};
        tbl[11] = '{OP_LH,  32'h0000_1000, 32'h0,         32'h0000_8000, 32'hFFFF_8000, 4'hF, 32'h0,         4, 3};

        rst_i = 1'b1;
        bellek_uop_i = '0;
        bel_istek_hazir_i = 1'b1;
        bel_yanit_veri_i = '0;
        bel_yanit_gecerli_i = 1'b0;
        @(posedge clk_i); @(posedge clk_i); #1;

        // Reset state
        chk("rst_gyu", geri_yaz_uop_o, '0);
        chk("rst_istek_gecerli", bel_istek_gecerli_o, 0);
        chk("rst_adres", bel_istek_adres_o, 0);
        chk("rst_veri", bel_istek_veri_o, 0);
        chk("rst_maske", bel_istek_maske_o, 0);
        chk("rst_odd", ddb_odd_gecerli_o, 0);
        chk("rst_duraklat", duraklat_o, 0);
        rst_i = 1'b0;

        // Table-driven transactions, zero-wait memory
        for (int i = 0; i < 12; i++) run_vec(i, tbl[i]);

        // SH with three cycles of backpressure
        begin
            int out_cyc;
            int stall_cnt;
            bit prev_stall;
            out_cyc = -1; stall_cnt = 0;
            bel_istek_hazir_i = 1'b0;
            @(posedge clk_i); #1;
            bellek_uop_i = mk_uop(1'b1, 32'h200, 32'h0000_2002, 32'h0000_ABCD, OP_SH);
            for (int c = 0; c < 9; c++) begin
                @(negedge clk_i);
                prev_stall = duraklat_o;
                if (duraklat_o) stall_cnt++;
                if (c >= 1 && c <= 4) begin
                    chk($sformatf("bp_c%0d_gecerli", c), bel_istek_gecerli_o, 1);
                    chk($sformatf("bp_c%0d_adres", c), bel_istek_adres_o, 32'h0000_2000);
                    chk($sformatf("bp_c%0d_veri", c), bel_istek_veri_o, 32'hABCD_ABCD);
                    chk($sformatf("bp_c%0d_maske", c), bel_istek_maske_o, 4'b1100);
                    chk($sformatf("bp_c%0d_yaz", c), bel_istek_yaz_o, 1);
                end
                if (geri_yaz_uop_o[0] && out_cyc < 0) begin
                    out_cyc = c;
                    chk("bp_rd", geri_yaz_uop_o[64:33], 32'h0000_2002);
                end
                @(posedge clk_i); #1;
                bel_istek_hazir_i = (c + 1 >= 4);
                if (!prev_stall) bellek_uop_i = '0;
            end
            chk("bp_out_cycle", out_cyc, 6);
            chk("bp_stall", stall_cnt, 5);
            bel_istek_hazir_i = 1'b1;
            bellek_uop_i = '0;
        end

        // Misaligned load and misaligned store
        for (int k = 0; k < 2; k++) begin
            logic [31:0] a;
            logic [3:0]  op;
            logic [3:0]  code;
            a    = (k == 0) ? 32'h0000_3001 : 32'h0000_3003;
            op   = (k == 0) ? OP_LW : OP_SH;
            code = (k == 0) ? 4'd4 : 4'd6;
            @(posedge clk_i); #1;
            bellek_uop_i = mk_uop(1'b1, 32'h300 + k, a, 32'h1, op);
            @(negedge clk_i);
            chk($sformatf("mis%0d_duraklat", k), duraklat_o, 0);
            chk($sformatf("mis%0d_odd_early", k), ddb_odd_gecerli_o, 0);
            @(posedge clk_i); #1;
            bellek_uop_i = '0;
            @(negedge clk_i);
            chk($sformatf("mis%0d_odd", k), ddb_odd_gecerli_o, 1);
            chk($sformatf("mis%0d_kod", k), ddb_odd_kod_o, code);
            chk($sformatf("mis%0d_bilgi", k), ddb_odd_bilgi_o, a);
            chk($sformatf("mis%0d_ps", k), ddb_odd_ps_o, 32'h300 + k);
            chk($sformatf("mis%0d_istek", k), bel_istek_gecerli_o, 0);
            chk($sformatf("mis%0d_gyu_valid", k), geri_yaz_uop_o[0], 0);
            @(negedge clk_i);
            chk($sformatf("mis%0d_odd_clear", k), ddb_odd_gecerli_o, 0);
            chk($sformatf("mis%0d_istek2", k), bel_istek_gecerli_o, 0);
        end

        // Back-to-back loads
        begin
            int  outs;
            int  n_req;
            int  last_req;
            int  stage;
            bit  prev_stall;
            outs = 0; n_req = 0; last_req = -10; stage = 0;
            @(posedge clk_i); #1;
            bellek_uop_i = mk_uop(1'b1, 32'h400, 32'h0000_4002, 32'h0, OP_LHU);
            for (int c = 0; c < 12; c++) begin
                @(negedge clk_i);
                prev_stall = duraklat_o;
                if (bel_istek_gecerli_o && bel_istek_hazir_i) begin
                    n_req++;
                    last_req = c;
                    if (n_req == 1) chk("b2b_req1_adres", bel_istek_adres_o, 32'h0000_4000);
                    if (n_req == 2) begin
                        chk("b2b_req2_adres", bel_istek_adres_o, 32'h0000_4008);
                        chk("b2b_req2_cycle", c, 5);
                    end
                end
                if (geri_yaz_uop_o[0]) begin
                    outs++;
                    if (outs == 1) begin
                        chk("b2b_out1_rd", geri_yaz_uop_o[64:33], 32'h0000_8765);
                        chk("b2b_out1_pc", geri_yaz_uop_o[32:1], 32'h400);
                    end
                    if (outs == 2) begin
                        chk("b2b_out2_rd", geri_yaz_uop_o[64:33], 32'h1111_2222);
                        chk("b2b_out2_pc", geri_yaz_uop_o[32:1], 32'h404);
                    end
                end
                @(posedge clk_i); #1;
                bel_yanit_gecerli_i = (c == last_req);
                bel_yanit_veri_i    = (n_req == 1) ? 32'h8765_0000 : 32'h1111_2222;
                if (!prev_stall) begin
                    nxt = (stage == 0) ? mk_uop(1'b1, 32'h404, 32'h0000_4008, 32'h0, OP_LW) : '0;
                    bellek_uop_i = nxt;
                    stage++;
                end
            end
            chk("b2b_outs", outs, 2);
            chk("b2b_reqs", n_req, 2);
            bellek_uop_i = '0;
            bel_yanit_gecerli_i = 1'b0;
        end

        // Reset while waiting for a load response
        begin
            int bad;
            bad = 0;
            @(posedge clk_i); #1;
            bellek_uop_i = mk_uop(1'b1, 32'h700, 32'h0000_7000, 32'h0, OP_LW);
            @(posedge clk_i); #1;
            @(posedge clk_i); #1;
            chk("rma_in_bekle", duraklat_o, 1);
            #1;
            rst_i = 1'b1;
            #1;
            chk("rma_gyu", geri_yaz_uop_o, '0);
            chk("rma_adres", bel_istek_adres_o, 0);
            chk("rma_maske", bel_istek_maske_o, 0);
            chk("rma_istek", bel_istek_gecerli_o, 0);
            chk("rma_duraklat", duraklat_o, 0);
            chk("rma_odd", ddb_odd_gecerli_o, 0);
            bellek_uop_i = '0;
            @(posedge clk_i); #1;
            rst_i = 1'b0;
            bel_yanit_gecerli_i = 1'b1;
            bel_yanit_veri_i = 32'hFFFF_FFFF;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk_i);
                if (geri_yaz_uop_o[0] || bel_istek_gecerli_o || duraklat_o) bad++;
                @(posedge clk_i); #1;
                bel_yanit_gecerli_i = 1'b0;
            end
            chk("rma_late_resp_ignored", bad, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
